// File: rtl/multiplier_array_pipe_pkg.sv
// Shared constants and helper functions for the pipelined array multiplier.
// Stage count and latency are derived from operand width and rows folded per stage.
package multiplier_array_pkg;

  localparam int DEFAULT_WIDTH          = 8;
  localparam int DEFAULT_ROWS_PER_STAGE = 2;

  function automatic int stages(input int width, input int rows);
    return (width + rows - 1) / rows;
  endfunction

  function automatic int latency(input int width, input int rows);
    return 1 + stages(width, rows);
  endfunction

endpackage

// File: rtl/multiplier_array_pipe_if.sv
// Operand/result stream bundle for the array multiplier.
// The slave modport is the multiplier's view; master is the producer/consumer side.
interface multiplier_array_pipe_if
  import multiplier_array_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] y;

  modport master (
    output in_valid, in_signed, a, b, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, in_signed, a, b, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/multiplier_array_pipe_stage.sv
// One accumulation stage: folds NUM_ROWS partial-product rows starting at FIRST_ROW
// into the running sum and forwards the multiplier bits not yet consumed.
module multiplier_array_stage
  import multiplier_array_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int FIRST_ROW = 0,
  parameter int NUM_ROWS  = DEFAULT_ROWS_PER_STAGE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [2*WIDTH-1:0] up_sum,
  input  logic [WIDTH-1:0]   up_a,
  input  logic [2*WIDTH-1:0] up_b,
  input  logic               up_mode,
  input  logic               up_valid,
  output logic [2*WIDTH-1:0] sum,
  output logic [WIDTH-1:0]   a_rest,
  output logic [2*WIDTH-1:0] b_ext,
  output logic               mode,
  output logic               valid
);
  localparam int W2 = 2 * WIDTH;

  logic [W2-1:0]    term [NUM_ROWS];
  logic [W2-1:0]    sum_next;
  logic [W2-1:0]    sum_reg;
  logic [WIDTH-1:0] a_reg;
  logic [W2-1:0]    b_reg;
  logic             mode_reg;
  logic             valid_reg;

  // up_a is already shifted so that its bit 0 is row FIRST_ROW.
  generate
    for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
      assign term[gi] = up_a[gi] ? (up_b << (FIRST_ROW + gi)) : '0;
    end
  endgenerate

  // The operand MSB carries weight -2^(WIDTH-1) in signed mode, so that row is subtracted.
  always_comb begin
    sum_next = up_sum;
    for (int j = 0; j < NUM_ROWS; j++) begin
      if (up_mode && (FIRST_ROW + j == WIDTH - 1)) begin
        sum_next = sum_next - term[j];
      end else begin
        sum_next = sum_next + term[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      mode_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else if (en) begin
      sum_reg   <= sum_next;
      a_reg     <= up_a >> NUM_ROWS;
      b_reg     <= up_b;
      mode_reg  <= up_mode;
      valid_reg <= up_valid;
    end
  end

  assign sum    = sum_reg;
  assign a_rest = a_reg;
  assign b_ext  = b_reg;
  assign mode   = mode_reg;
  assign valid  = valid_reg;
endmodule

// File: rtl/multiplier_array_pipe.sv
// Pipelined shift-and-add array multiplier with valid/ready handshake and signed mode.
// Stage 0 captures operands; a chain of accumulation stages folds ROWS_PER_STAGE rows each.
module multiplier_array_pipe
  import multiplier_array_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int ROWS_PER_STAGE = DEFAULT_ROWS_PER_STAGE
) (
  input logic                    clk,
  input logic                    rst_n,
  multiplier_array_pipe_if.slave bus
);
  localparam int S  = stages(WIDTH, ROWS_PER_STAGE);
  localparam int W2 = 2 * WIDTH;

  logic             stall;
  logic             advance;
  logic [W2-1:0]    b_ext_next;
  logic [WIDTH-1:0] a_reg;
  logic [W2-1:0]    b_reg;
  logic             mode_reg;
  logic             valid_reg;

  logic [W2-1:0]    sum_c   [S+1];
  logic [WIDTH-1:0] a_c     [S+1];
  logic [W2-1:0]    b_c     [S+1];
  logic             mode_c  [S+1];
  logic             valid_c [S+1];

  // Stalls freeze the whole pipe, bubbles included, so ready depends only on the tail.
  assign stall        = valid_c[S] & ~bus.out_ready;
  assign advance      = ~stall;
  assign bus.in_ready = advance;

  assign b_ext_next = bus.in_signed ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b}
                                    : {{WIDTH{1'b0}}, bus.b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      mode_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else if (advance) begin
      valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        a_reg    <= bus.a;
        b_reg    <= b_ext_next;
        mode_reg <= bus.in_signed;
      end
    end
  end

  assign sum_c[0]   = '0;
  assign a_c[0]     = a_reg;
  assign b_c[0]     = b_reg;
  assign mode_c[0]  = mode_reg;
  assign valid_c[0] = valid_reg;

  // The final stage absorbs whatever rows remain when WIDTH is not a multiple of R.
  generate
    for (genvar gi = 0; gi < S; gi++) begin : g_stage
      localparam int FIRST = gi * ROWS_PER_STAGE;
      localparam int NUM   = (gi == S - 1) ? (WIDTH - (S - 1) * ROWS_PER_STAGE)
                                           : ROWS_PER_STAGE;
      multiplier_array_stage #(
        .WIDTH     (WIDTH),
        .FIRST_ROW (FIRST),
        .NUM_ROWS  (NUM)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (advance),
        .up_sum   (sum_c[gi]),
        .up_a     (a_c[gi]),
        .up_b     (b_c[gi]),
        .up_mode  (mode_c[gi]),
        .up_valid (valid_c[gi]),
        .sum      (sum_c[gi+1]),
        .a_rest   (a_c[gi+1]),
        .b_ext    (b_c[gi+1]),
        .mode     (mode_c[gi+1]),
        .valid    (valid_c[gi+1])
      );
    end
  endgenerate

  assign bus.y         = sum_c[S];
  assign bus.out_valid = valid_c[S];
endmodule

// File: tb/tb_multiplier_array_pipe.sv
// Self-checking bench: five multiplier configurations checked against an integer a*b model.
// Instance 0 is WIDTH=8, R=2; instances 1..4 cover the parameter sweep.
module tb_multiplier_array_pipe;
  localparam int NCFG = 5;

  function automatic int cfg_w(input int i);
    case (i)
      0: return 8;
      1: return 2;
      2: return 8;
      3: return 16;
      default: return 13;
    endcase
  endfunction

  function automatic int cfg_r(input int i);
    case (i)
      0: return 2;
      1: return 1;
      2: return 3;
      3: return 16;
      default: return 4;
    endcase
  endfunction

  function automatic int lat(input int i);
    return 1 + (cfg_w(i) + cfg_r(i) - 1) / cfg_r(i);
  endfunction

  // Product of the low w bits of a and b, interpreted per mode, reduced mod 2^(2w).
  function automatic logic [31:0] ref_mul(input int w, input logic sgn,
                                          input logic [15:0] a, input logic [15:0] b);
    longint av, bv, p, m;
    m  = (longint'(1) << w) - 1;
    av = longint'(a) & m;
    bv = longint'(b) & m;
    if (sgn && av >= (longint'(1) << (w - 1))) av = av - (longint'(1) << w);
    if (sgn && bv >= (longint'(1) << (w - 1))) bv = bv - (longint'(1) << w);
    p = (av * bv) & ((longint'(1) << (2 * w)) - 1);
    return p[31:0];
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                   drv_valid  [NCFG];
  logic                   drv_signed [NCFG];
  logic                   drv_ready  [NCFG];
  logic [15:0]            drv_a      [NCFG];
  logic [15:0]            drv_b      [NCFG];
  logic [NCFG-1:0]        obs_in_ready;
  logic [NCFG-1:0]        obs_out_valid;
  logic [NCFG-1:0][31:0]  obs_y;

  int n_checks = 0;
  int n_fail   = 0;

  generate
    for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
      localparam int W = cfg_w(gi);
      localparam int R = cfg_r(gi);
      multiplier_array_pipe_if #(.WIDTH(W)) bus ();
      assign bus.in_valid  = drv_valid[gi];
      assign bus.in_signed = drv_signed[gi];
      assign bus.a         = drv_a[gi][W-1:0];
      assign bus.b         = drv_b[gi][W-1:0];
      assign bus.out_ready = drv_ready[gi];
      assign obs_in_ready[gi]  = bus.in_ready;
      assign obs_out_valid[gi] = bus.out_valid;
      assign obs_y[gi]         = 32'(bus.y);
      multiplier_array_pipe #(.WIDTH(W), .ROWS_PER_STAGE(R)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
      );
    end
  endgenerate

  task automatic idle_all();
    for (int i = 0; i < NCFG; i++) begin
      drv_valid[i]  = 1'b0;
      drv_signed[i] = 1'b0;
      drv_ready[i]  = 1'b1;
      drv_a[i]      = '0;
      drv_b[i]      = '0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NCFG; i++) begin
      n_checks++;
      if (obs_out_valid[i] !== 1'b0) begin
        n_fail++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", i, obs_out_valid[i]);
      end
      n_checks++;
      if (obs_y[i] !== 32'h0) begin
        n_fail++; $display("FAIL reset_y[%0d]: got %h expected 0", i, obs_y[i]);
      end
      n_checks++;
      if (obs_in_ready[i] !== 1'b1) begin
        n_fail++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", i, obs_in_ready[i]);
      end
    end
    $display("reset: outputs checked on %0d instances", NCFG);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned_max();
    int  L = lat(0);
    bit  exp_v;
    drv_valid[0] = 1'b1; drv_signed[0] = 1'b0;
    drv_a[0] = 16'h00FF; drv_b[0] = 16'h00FF;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (n == 0) begin
        n_checks++;
        if (obs_in_ready[0] !== 1'b1) begin
          n_fail++; $display("FAIL umax_in_ready: got %b expected 1", obs_in_ready[0]);
        end
      end
      exp_v = (n == L);
      n_checks++;
      if (obs_out_valid[0] !== exp_v) begin
        n_fail++; $display("FAIL umax_out_valid cycle %0d: got %b expected %b", n, obs_out_valid[0], exp_v);
      end
      if (exp_v) begin
        n_checks++;
        if (obs_y[0] !== 32'h0000FE01) begin
          n_fail++; $display("FAIL umax_y: got %h expected 0000fe01", obs_y[0]);
        end
        $display("umax: 0xff*0xff -> %h at cycle %0d", obs_y[0], n);
      end
      @(posedge clk); #1;
      drv_valid[0] = 1'b0;
    end
  endtask

  task automatic test_signed_corners();
    int          L = lat(0);
    logic [15:0] ta [3];
    logic [15:0] tb [3];
    logic [31:0] ey [3];
    bit          exp_v;
    ta[0] = 16'h0080; tb[0] = 16'h0080; ey[0] = 32'h00004000;
    ta[1] = 16'h00FF; tb[1] = 16'h007F; ey[1] = 32'h0000FF81;
    ta[2] = 16'h007F; tb[2] = 16'h0080; ey[2] = 32'h0000C080;
    for (int n = 0; n < 12; n++) begin
      if (n < 3) begin
        drv_valid[0] = 1'b1; drv_signed[0] = 1'b1; drv_a[0] = ta[n]; drv_b[0] = tb[n];
      end else begin
        drv_valid[0] = 1'b0;
      end
      @(negedge clk);
      exp_v = (n >= L) && (n < L + 3);
      n_checks++;
      if (obs_out_valid[0] !== exp_v) begin
        n_fail++; $display("FAIL signed_out_valid cycle %0d: got %b expected %b", n, obs_out_valid[0], exp_v);
      end
      if (exp_v) begin
        n_checks++;
        if (obs_y[0] !== ey[n-L]) begin
          n_fail++; $display("FAIL signed_y[%0d]: got %h expected %h", n - L, obs_y[0], ey[n-L]);
        end
        $display("signed: %h*%h -> %h", ta[n-L][7:0], tb[n-L][7:0], obs_y[0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int          L = lat(0);
    logic [31:0] ey [16];
    bit          exp_v;
    for (int n = 0; n < 16 + L + 3; n++) begin
      if (n < 16) begin
        drv_valid[0]  = 1'b1;
        drv_signed[0] = 1'($urandom_range(0, 1));
        drv_a[0]      = 16'($urandom);
        drv_b[0]      = 16'($urandom);
        ey[n]         = ref_mul(8, drv_signed[0], drv_a[0], drv_b[0]);
      end else begin
        drv_valid[0] = 1'b0;
      end
      @(negedge clk);
      if (n < 16) begin
        n_checks++;
        if (obs_in_ready[0] !== 1'b1) begin
          n_fail++; $display("FAIL b2b_in_ready cycle %0d: got %b expected 1", n, obs_in_ready[0]);
        end
      end
      exp_v = (n >= L) && (n < 16 + L);
      n_checks++;
      if (obs_out_valid[0] !== exp_v) begin
        n_fail++; $display("FAIL b2b_out_valid cycle %0d: got %b expected %b", n, obs_out_valid[0], exp_v);
      end
      if (exp_v) begin
        n_checks++;
        if (obs_y[0] !== ey[n-L]) begin
          n_fail++; $display("FAIL b2b_y[%0d]: got %h expected %h", n - L, obs_y[0], ey[n-L]);
        end
        $display("b2b: result %0d = %h", n - L, obs_y[0]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Five pairs in flight, out_ready low for cycles 5..7; a sixth pair waits at the input.
  task automatic test_stall();
    logic [15:0] ta [6];
    logic [15:0] tb [6];
    logic        ts [6];
    logic [31:0] ey [6];
    bit          exp_v, exp_rdy;
    int          k, ei;
    for (int i = 0; i < 6; i++) begin
      ta[i] = 16'($urandom); tb[i] = 16'($urandom); ts[i] = 1'($urandom_range(0, 1));
      ey[i] = ref_mul(8, ts[i], ta[i], tb[i]);
    end
    for (int n = 0; n < 18; n++) begin
      drv_ready[0] = !(n >= 5 && n <= 7);
      k = (n < 5) ? n : 5;
      if (n <= 8) begin
        drv_valid[0] = 1'b1; drv_signed[0] = ts[k]; drv_a[0] = ta[k]; drv_b[0] = tb[k];
      end else begin
        drv_valid[0] = 1'b0;
      end
      @(negedge clk);
      exp_rdy = !(n >= 5 && n <= 7);
      exp_v   = (n >= 5) && (n <= 13);
      ei      = (n <= 8) ? 0 : n - 8;
      n_checks++;
      if (obs_in_ready[0] !== exp_rdy) begin
        n_fail++; $display("FAIL stall_in_ready cycle %0d: got %b expected %b", n, obs_in_ready[0], exp_rdy);
      end
      n_checks++;
      if (obs_out_valid[0] !== exp_v) begin
        n_fail++; $display("FAIL stall_out_valid cycle %0d: got %b expected %b", n, obs_out_valid[0], exp_v);
      end
      if (exp_v) begin
        n_checks++;
        if (obs_y[0] !== ey[ei]) begin
          n_fail++; $display("FAIL stall_y cycle %0d: got %h expected %h", n, obs_y[0], ey[ei]);
        end
        $display("stall: cycle %0d ready=%b y=%h", n, drv_ready[0], obs_y[0]);
      end
      @(posedge clk); #1;
    end
    drv_ready[0] = 1'b1;
  endtask

  task automatic test_reset_midstream();
    int          L = lat(0);
    logic [31:0] ey [4];
    logic [31:0] ey_new;
    bit          exp_v;
    for (int n = 0; n < 5; n++) begin
      if (n < 4) begin
        drv_valid[0] = 1'b1; drv_signed[0] = 1'b0;
        drv_a[0] = 16'($urandom) | 16'h0001; drv_b[0] = 16'($urandom) | 16'h0001;
        ey[n] = ref_mul(8, 1'b0, drv_a[0], drv_b[0]);
      end else begin
        drv_valid[0] = 1'b0;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (obs_out_valid[0] !== 1'b1 || obs_y[0] !== ey[0]) begin
      n_fail++; $display("FAIL rstmid_before: got v=%b y=%h expected v=1 y=%h", obs_out_valid[0], obs_y[0], ey[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs_out_valid[0] !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_out_valid: got %b expected 0", obs_out_valid[0]);
    end
    n_checks++;
    if (obs_y[0] !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_y: got %h expected 0", obs_y[0]);
    end
    n_checks++;
    if (obs_in_ready[0] !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_in_ready: got %b expected 1", obs_in_ready[0]);
    end
    $display("rstmid: async reset cleared v=%b y=%h", obs_out_valid[0], obs_y[0]);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    ey_new = '0;
    for (int n = 0; n < 12; n++) begin
      if (n == 0) begin
        drv_valid[0] = 1'b1; drv_signed[0] = 1'b1;
        drv_a[0] = 16'($urandom); drv_b[0] = 16'($urandom);
        ey_new = ref_mul(8, 1'b1, drv_a[0], drv_b[0]);
      end else begin
        drv_valid[0] = 1'b0;
      end
      @(negedge clk);
      exp_v = (n == L);
      n_checks++;
      if (obs_out_valid[0] !== exp_v) begin
        n_fail++; $display("FAIL rstmid_after_valid cycle %0d: got %b expected %b", n, obs_out_valid[0], exp_v);
      end
      if (exp_v) begin
        n_checks++;
        if (obs_y[0] !== ey_new) begin
          n_fail++; $display("FAIL rstmid_after_y: got %h expected %h", obs_y[0], ey_new);
        end
        $display("rstmid: first result after release %h", obs_y[0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_param_sweep();
    logic [31:0] ey [NCFG][64];
    bit          ev [NCFG][64];
    for (int i = 0; i < NCFG; i++) begin
      for (int c = 0; c < 64; c++) begin
        ev[i][c] = 1'b0; ey[i][c] = '0;
      end
    end
    for (int n = 0; n < 40; n++) begin
      for (int i = 1; i < NCFG; i++) begin
        if (n < 24 && $urandom_range(0, 3) != 0) begin
          drv_valid[i]  = 1'b1;
          drv_signed[i] = 1'($urandom_range(0, 1));
          drv_a[i]      = 16'($urandom);
          drv_b[i]      = 16'($urandom);
          ev[i][n + lat(i)] = 1'b1;
          ey[i][n + lat(i)] = ref_mul(cfg_w(i), drv_signed[i], drv_a[i], drv_b[i]);
        end else begin
          drv_valid[i] = 1'b0;
        end
      end
      @(negedge clk);
      for (int i = 1; i < NCFG; i++) begin
        n_checks++;
        if (obs_in_ready[i] !== 1'b1) begin
          n_fail++; $display("FAIL sweep_in_ready[%0d] cycle %0d: got %b expected 1", i, n, obs_in_ready[i]);
        end
        n_checks++;
        if (obs_out_valid[i] !== ev[i][n]) begin
          n_fail++; $display("FAIL sweep_out_valid[%0d] cycle %0d: got %b expected %b", i, n, obs_out_valid[i], ev[i][n]);
        end
        if (ev[i][n]) begin
          n_checks++;
          if (obs_y[i] !== ey[i][n]) begin
            n_fail++; $display("FAIL sweep_y[%0d] cycle %0d: got %h expected %h", i, n, obs_y[i], ey[i][n]);
          end
          $display("sweep: W=%0d R=%0d cycle %0d y=%h", cfg_w(i), cfg_r(i), n, obs_y[i]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed_corners();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multiplier_array_pipe.md
# multiplier_array_pipe

Parametrised, pipelined shift-and-add array multiplier with a valid/ready stream interface and run-time signed/unsigned mode. It produces the full 2·WIDTH product. Throughput is one product per clock, and latency is set by how many partial-product rows are folded into each pipeline stage. It is the next-generation drop-in for the array-multiplier datapath in the RTL examples, generalised in width and stage depth, and adding handshake, stall and signed support.

## Interface
- WIDTH, default 8: operand width, legal range ≥ 2.
- ROWS_PER_STAGE, default 2: partial-product rows accumulated per pipeline stage, legal range 1..WIDTH.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset. Single clock domain.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands this cycle.
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned. Sampled with the operands.
- a  input  WIDTH  multiplier operand.
- b  input  WIDTH  multiplicand operand.
- out_valid  output  1  y holds a result.
- out_ready  input  1  consumer accepts y this cycle.
- y  output  2·WIDTH  full product.

## Operation
- Derived values: S = ceil(WIDTH / ROWS_PER_STAGE) accumulation stages. Latency L = 1 + S.
- Stage 0 registers a, b, in_signed and in_valid when accepted.
- b is extended to 2·WIDTH bits: sign-extended if signed, zero-extended otherwise.
- Stage k (1..S) adds rows i = (k−1)·R .. min(k·R, WIDTH)−1 to the incoming partial sum. Row i contributes (a[i] ? B<<i : 0).
- Signed mode: row WIDTH−1 is subtracted rather than added, which implements the −2^(WIDTH−1) weight of the a MSB.
- All arithmetic is modulo 2^(2·WIDTH). No overflow can occur.
- Each stage carries forward its partial sum, the not-yet-consumed a bits, the extended B, the mode bit and the valid bit.
- y is the stage-S partial sum; out_valid is the stage-S valid bit.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - Transfer in occurs on in_valid & in_ready. Transfer out occurs on out_valid & out_ready.
- Stall freezes every stage register, including invalid bubbles. Bubbles are not collapsed.
- When not stalled, every stage advances each cycle. A stage with valid = 0 carries don't-care data, but its valid bit is always exact.
- in_valid while in_ready = 0 is ignored; the source must hold its operands.

## Timing
- Reset (rst_n low, asynchronous): all valid bits are 0 and all data registers are 0. Outputs during reset: out_valid = 0, y = 0, in_ready = 1.
- Reset mid-operation discards every in-flight product. The first result after release is the first operand pair accepted after release.
- Deassertion of rst_n is synchronised externally. The block adds no reset synchroniser.
- Operands accepted at edge t with no stall produce out_valid = 1 and the correct y in the cycle following edge t+L−1, i.e. y is visible L cycles after the accepting edge.
  - Example: WIDTH = 8, R = 2 gives L = 5.
- With out_ready held at 1, sustained throughput is 1 product per cycle.
- Each stall cycle adds exactly 1 cycle to the latency of every product in flight.
- Simultaneous in_valid and out_ready with out_valid = 1: the output transfers and a new input is accepted on the same edge.
- y and out_valid are held stable while stalled.

## Structure
- Shared package multiplier_array_pkg:
  - function stages(width, rows) returning ceil(width/rows).
  - function latency(width, rows) returning 1 + stages(width, rows).
  - localparam defaults for WIDTH and ROWS_PER_STAGE.
- Sub-module multiplier_array_stage, one per accumulation stage, instantiated S times via generate.
  - Parameters: WIDTH, FIRST_ROW, NUM_ROWS.
  - Registered partial-sum, a, B, mode and valid, with an enable = ~stall.
  - The last stage is instantiated with NUM_ROWS = WIDTH − (S−1)·R.
- The top level contains the input register stage, the stall/ready logic and the stage chain.

## Test plan
- WIDTH = 8, R = 2, unsigned 0xFF × 0xFF, out_ready = 1 → y = 0xFE01, out_valid high exactly 5 cycles after acceptance, then low.
- Signed mode: −128 × −128 → 0x4000; −1 × 127 → 0xFF81; 127 × −128 → 0xC080.
- Back-to-back streaming, one pair per cycle for 16 cycles with mixed modes → 16 correct results in order on consecutive cycles, compared against a behavioural a×b model.
- Drop out_ready for 3 cycles with 5 products in flight → in_ready = 0 and y frozen for those 3 cycles; all results correct, none lost or duplicated, latency +3.
- Assert rst_n low for 1 cycle mid-stream with 4 products in flight → out_valid = 0 and y = 0 immediately (asynchronously); no stale product appears after release.
- Parameter sweep: (WIDTH, R) ∈ {(2,1), (8,3), (16,16), (13,4)}, random operands in both modes → results match the model, with latency = 1 + ceil(WIDTH/R).
